// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-port round-robin arbiter for the multiplexed ALE/En/Rw memory bus
// Optional data-phase wait/timeout support: define BUS_WAIT_EN.
module mem_bus_arbiter #(
  parameter int DATA_W = 8
`ifdef BUS_WAIT_EN
  , parameter int WAIT_MAX = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              rw0,
  input  logic              rw1,
  input  logic [DATA_W-1:0] addr0,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic              bus_err,
  output logic              ALE,
  output logic              En,
  output logic              Rw,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
`ifdef BUS_WAIT_EN
  input  logic              mem_wait,
`endif
  input  logic [DATA_W-1:0] bus_in
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e              state_q;
  logic                last_q;
  logic                sel_q;
  logic                rw_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                gnt0_q, gnt1_q, ack0_q, ack1_q;
  logic                ale_q, en_q, rw_out_q, oe_q;
  logic [DATA_W-1:0]   bus_out_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                sel_d;
  logic                data_exit_d;

`ifdef BUS_WAIT_EN
  localparam int CW = $clog2(WAIT_MAX + 1);
  logic [CW-1:0] wait_cnt_q;
  logic          bus_err_q;

  assign data_exit_d = !mem_wait || (wait_cnt_q == CW'(WAIT_MAX));
  assign bus_err     = bus_err_q;
`else
  assign data_exit_d = 1'b1;
  assign bus_err     = 1'b0;
`endif

  // Single requester wins outright; a tie goes to the port that did not win last.
  always_comb begin
    sel_d = 1'b0;
    if (req0 && req1) sel_d = ~last_q;
    else if (req1)    sel_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      sel_q     <= 1'b0;
      rw_q      <= 1'b1;
      wdata_q   <= '0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      ale_q     <= 1'b0;
      en_q      <= 1'b0;
      rw_out_q  <= 1'b1;
      oe_q      <= 1'b0;
      bus_out_q <= '0;
      rdata_q   <= '0;
`ifdef BUS_WAIT_EN
      wait_cnt_q <= '0;
      bus_err_q  <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
`ifdef BUS_WAIT_EN
      bus_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (req0 || req1) begin
            state_q   <= ADDR;
            sel_q     <= sel_d;
            last_q    <= sel_d;
            rw_q      <= sel_d ? rw1 : rw0;
            wdata_q   <= sel_d ? wdata1 : wdata0;
            gnt0_q    <= ~sel_d;
            gnt1_q    <= sel_d;
            ale_q     <= 1'b1;
            oe_q      <= 1'b1;
            bus_out_q <= sel_d ? addr1 : addr0;
            rw_out_q  <= sel_d ? rw1 : rw0;
`ifdef BUS_WAIT_EN
            wait_cnt_q <= '0;
`endif
          end
        end
        ADDR: begin
          state_q   <= DATA;
          ale_q     <= 1'b0;
          en_q      <= 1'b1;
          oe_q      <= ~rw_q;
          bus_out_q <= rw_q ? '0 : wdata_q;
        end
        DATA: begin
          if (data_exit_d) begin
            state_q   <= DONE;
            en_q      <= 1'b0;
            oe_q      <= 1'b0;
            bus_out_q <= '0;
            rw_out_q  <= 1'b1;
            ack0_q    <= ~sel_q;
            ack1_q    <= sel_q;
            if (rw_q) rdata_q <= bus_in;
`ifdef BUS_WAIT_EN
            bus_err_q <= mem_wait;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
`endif
          end
        end
        DONE: begin
          state_q <= IDLE;
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          gnt0_q    <= 1'b0;
          gnt1_q    <= 1'b0;
          ale_q     <= 1'b0;
          en_q      <= 1'b0;
          rw_out_q  <= 1'b1;
          oe_q      <= 1'b0;
          bus_out_q <= '0;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign ack0    = ack0_q;
  assign ack1    = ack1_q;
  assign rdata   = rdata_q;
  assign ALE     = ale_q;
  assign En      = en_q;
  assign Rw      = rw_out_q;
  assign bus_out = bus_out_q;
  assign bus_oe  = oe_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       req0 = 1'b0, req1 = 1'b0, rw0 = 1'b1, rw1 = 1'b1;
  logic [7:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0, bus_in = '0;
  logic       gnt0, gnt1, ack0, ack1, bus_err, ALE, En, Rw, bus_oe;
  logic [7:0] rdata, bus_out;
`ifdef BUS_WAIT_EN
  logic       mem_wait = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .bus_err(bus_err),
    .ALE(ALE), .En(En), .Rw(Rw), .bus_out(bus_out), .bus_oe(bus_oe),
`ifdef BUS_WAIT_EN
    .mem_wait(mem_wait),
`endif
    .bus_in(bus_in)
  );

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL rst_gnt act=%b%b exp=00", gnt0, gnt1); end
    total++; if (ack0 !== 1'b0 || ack1 !== 1'b0) begin bad++; $display("FAIL rst_ack act=%b%b exp=00", ack0, ack1); end
    total++; if ({ALE, En, Rw, bus_oe} !== 4'b0010) begin bad++; $display("FAIL rst_bus act=%b exp=0010", {ALE, En, Rw, bus_oe}); end
    total++; if (bus_out !== 8'h00 || rdata !== 8'h00 || bus_err !== 1'b0) begin bad++; $display("FAIL rst_data act=%h/%h/%b exp=00/00/0", bus_out, rdata, bus_err); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++; if ({gnt0, gnt1, ALE, En, Rw, bus_oe} !== 6'b000010) begin bad++; $display("FAIL idle_hold act=%b exp=000010", {gnt0, gnt1, ALE, En, Rw, bus_oe}); end
  endtask

  task automatic test_read();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h3C; bus_in = 8'hA5;
    @(negedge clk);
    total++; if (ALE !== 1'b1 || bus_out !== 8'h3C || bus_oe !== 1'b1) begin bad++; $display("FAIL rd_addr act=%b/%h/%b exp=1/3c/1", ALE, bus_out, bus_oe); end
    total++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || En !== 1'b0) begin bad++; $display("FAIL rd_gnt act=%b%b en=%b exp=10 en=0", gnt0, gnt1, En); end
    req0 = 1'b0;
    @(negedge clk);
    total++; if ({ALE, En, Rw, bus_oe} !== 4'b0110) begin bad++; $display("FAIL rd_data act=%b exp=0110", {ALE, En, Rw, bus_oe}); end
    @(negedge clk);
    total++; if (ack0 !== 1'b1 || ack1 !== 1'b0 || rdata !== 8'hA5) begin bad++; $display("FAIL rd_done act=%b%b/%h exp=10/a5", ack0, ack1, rdata); end
    total++; if (En !== 1'b0 || bus_oe !== 1'b0 || gnt0 !== 1'b1 || bus_err !== 1'b0) begin bad++; $display("FAIL rd_done_bus act=%b%b%b%b exp=0010", En, bus_oe, gnt0, bus_err); end
    bus_in = 8'h00;
    @(negedge clk);
    total++; if (ack0 !== 1'b0 || gnt0 !== 1'b0 || rdata !== 8'hA5) begin bad++; $display("FAIL rd_after act=%b%b/%h exp=00/a5", ack0, gnt0, rdata); end
  endtask

  task automatic test_write();
    req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h10; wdata1 = 8'h7E;
    @(negedge clk);
    total++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || ALE !== 1'b1 || bus_out !== 8'h10 || Rw !== 1'b0) begin bad++; $display("FAIL wr_addr act=%b%b%b/%h/%b exp=101/10/0", gnt1, gnt0, ALE, bus_out, Rw); end
    wdata1 = 8'h00;
    @(negedge clk);
    total++; if ({ALE, En, Rw, bus_oe} !== 4'b0101 || bus_out !== 8'h7E) begin bad++; $display("FAIL wr_data act=%b/%h exp=0101/7e", {ALE, En, Rw, bus_oe}, bus_out); end
    req1 = 1'b0;
    @(negedge clk);
    total++; if (ack1 !== 1'b1 || ack0 !== 1'b0 || Rw !== 1'b1 || bus_oe !== 1'b0 || rdata !== 8'hA5) begin bad++; $display("FAIL wr_done act=%b%b%b%b/%h exp=1010/a5", ack1, ack0, Rw, bus_oe, rdata); end
    @(negedge clk);
    total++; if (ack1 !== 1'b0 || gnt1 !== 1'b0) begin bad++; $display("FAIL wr_after act=%b%b exp=00", ack1, gnt1); end
  endtask

  task automatic test_round_robin();
    int order[$];
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h01;
    req1 = 1'b1; rw1 = 1'b0; addr1 = 8'h02; wdata1 = 8'h55;
    bus_in = 8'h99;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      total++; if (gnt0 === 1'b1 && gnt1 === 1'b1) begin bad++; $display("FAIL rr_gnt_excl cyc=%0d act=11 exp=not11", k); end
      total++; if (ack0 === 1'b1 && ack1 === 1'b1) begin bad++; $display("FAIL rr_ack_excl cyc=%0d act=11 exp=not11", k); end
      if (ack0 === 1'b1) begin
        order.push_back(0);
        total++; if (gnt0 !== 1'b1) begin bad++; $display("FAIL rr_ack0_gnt cyc=%0d act=%b exp=1", k, gnt0); end
      end
      if (ack1 === 1'b1) begin
        order.push_back(1);
        total++; if (gnt1 !== 1'b1) begin bad++; $display("FAIL rr_ack1_gnt cyc=%0d act=%b exp=1", k, gnt1); end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    total++; if (order.size() !== 4) begin bad++; $display("FAIL rr_count act=%0d exp=4", order.size()); end
    for (int i = 0; i < 4 && i < order.size(); i++) begin
      total++; if (order[i] !== (i % 2)) begin bad++; $display("FAIL rr_order idx=%0d act=%0d exp=%0d", i, order[i], i % 2); end
    end
    total++; if (rdata !== 8'h99) begin bad++; $display("FAIL rr_rdata act=%h exp=99", rdata); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h44; bus_in = 8'h5A;
    repeat (2) @(negedge clk);
    total++; if (En !== 1'b1 || gnt0 !== 1'b1) begin bad++; $display("FAIL rm_pre act=%b%b exp=11", En, gnt0); end
    req0 = 1'b0;
    #1 rst = 1'b0;
    #1;
    total++; if ({En, ALE, bus_oe, gnt0, gnt1} !== 5'b00000) begin bad++; $display("FAIL rm_abort act=%b exp=00000", {En, ALE, bus_oe, gnt0, gnt1}); end
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL rm_rdata act=%h exp=00", rdata); end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      total++; if (ack0 !== 1'b0 || ack1 !== 1'b0 || gnt0 !== 1'b0) begin bad++; $display("FAIL rm_noack cyc=%0d act=%b%b%b exp=000", k, ack0, ack1, gnt0); end
    end
  endtask

  task automatic test_req_drop();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h21; bus_in = 8'hC3;
    @(negedge clk);
    total++; if (ALE !== 1'b1 || gnt0 !== 1'b1) begin bad++; $display("FAIL rd_drop_addr act=%b%b exp=11", ALE, gnt0); end
    req0 = 1'b0;
    @(negedge clk);
    total++; if (En !== 1'b1) begin bad++; $display("FAIL rd_drop_data act=%b exp=1", En); end
    @(negedge clk);
    total++; if (ack0 !== 1'b1 || rdata !== 8'hC3) begin bad++; $display("FAIL rd_drop_ack act=%b/%h exp=1/c3", ack0, rdata); end
    @(negedge clk);
    total++; if (ack0 !== 1'b0 || gnt0 !== 1'b0) begin bad++; $display("FAIL rd_drop_idle act=%b%b exp=00", ack0, gnt0); end
    @(negedge clk);
    total++; if (gnt0 !== 1'b0 || ALE !== 1'b0) begin bad++; $display("FAIL rd_drop_stay act=%b%b exp=00", gnt0, ALE); end
  endtask

`ifdef BUS_WAIT_EN
  task automatic test_wait();
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h30; bus_in = 8'h66; mem_wait = 1'b1;
    @(negedge clk);
    req0 = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      total++; if (En !== 1'b1 || ack0 !== 1'b0) begin bad++; $display("FAIL wt_en cyc=%0d act=%b%b exp=10", k, En, ack0); end
    end
    mem_wait = 1'b0;
    @(negedge clk);
    total++; if (ack0 !== 1'b1 || bus_err !== 1'b0 || En !== 1'b0 || rdata !== 8'h66) begin bad++; $display("FAIL wt_done act=%b%b%b/%h exp=100/66", ack0, bus_err, En, rdata); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int en_cycles;
    req0 = 1'b1; rw0 = 1'b1; addr0 = 8'h31; bus_in = 8'h77; mem_wait = 1'b1;
    en_cycles = 0;
    @(negedge clk);
    req0 = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      if (En === 1'b1) en_cycles++;
      total++; if (ack0 !== 1'b0) begin bad++; $display("FAIL to_early cyc=%0d act=%b exp=0", k, ack0); end
    end
    total++; if (en_cycles !== 16) begin bad++; $display("FAIL to_en_cycles act=%0d exp=16", en_cycles); end
    @(negedge clk);
    total++; if (ack0 !== 1'b1 || bus_err !== 1'b1 || rdata !== 8'h77) begin bad++; $display("FAIL to_done act=%b%b/%h exp=11/77", ack0, bus_err, rdata); end
    mem_wait = 1'b0;
    @(negedge clk);
    total++; if (bus_err !== 1'b0 || ack0 !== 1'b0) begin bad++; $display("FAIL to_after act=%b%b exp=00", bus_err, ack0); end
  endtask
`endif

  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_reset_mid();
    test_req_drop();
`ifdef BUS_WAIT_EN
    test_wait();
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
